// File: rtl/alu_pkg.sv
// Shared opcode and FSM types for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpNot  = 4'd2,
    OpAnd  = 4'd3,
    OpOr   = 4'd4,
    OpXor  = 4'd5,
    OpSlt  = 4'd6,
    OpEq   = 4'd7,
    OpMulu = 4'd8,
    OpDivu = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam int unsigned NumOps = 10;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one step per cycle.
// lo/hi present the step result, so the caller can register the final words with done.
module alu_muldiv #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    lo_q, lo_d, hi_q, hi_d, b_q, b_d;
  logic            div_q, div_d, busy_q, busy_d;
  logic [W:0]      add_s, shl, sub_s;

  always_comb begin
    cnt_d  = cnt_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    b_d    = b_q;
    div_d  = div_q;
    busy_d = busy_q;
    add_s  = {1'b0, hi_q} + {1'b0, b_q};
    shl    = {hi_q, lo_q[W-1]};
    sub_s  = shl - {1'b0, b_q};
    if (start) begin
      lo_d   = a;
      hi_d   = '0;
      b_d    = b;
      div_d  = is_div;
      cnt_d  = CntW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) busy_d = 1'b0;
      if (div_q) begin
        // Partial remainder never exceeds the divisor, so bit W of sub_s is the borrow.
        if (!sub_s[W]) begin
          hi_d = sub_s[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = shl[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end else if (lo_q[0]) begin
        {hi_d, lo_d} = {add_s, lo_q[W-1:1]};
      end else begin
        {hi_d, lo_d} = {1'b0, hi_q, lo_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      b_q    <= b_d;
      div_q  <= div_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CntW'(1));
  assign lo   = lo_d;
  assign hi   = hi_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative MULU/DIVU, one op in flight.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [W-1:0] res_hi,
  output logic         car,
  output logic         of,
  output logic         zf,
  output logic         dz
);

  state_e       state_q, state_d;
  logic [W-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic         car_q, car_d, of_q, of_d, zf_q, zf_d, dz_q, dz_d;

  logic [W-1:0] r_res, r_hi;
  logic         r_car, r_of, r_dz;
  logic [W:0]   sum, dif;
  logic         accept, iterative, md_start, md_busy, md_done;
  logic [W-1:0] md_lo, md_hi;

  assign accept    = (state_q == StIdle) && in_valid;
  assign iterative = (op == OpMulu) || ((op == OpDivu) && (b != '0));
  assign md_start  = accept && iterative;

  alu_muldiv #(
    .W(W)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .is_div(op == OpDivu),
    .a     (a),
    .b     (b),
    .busy  (md_busy),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = iterative ? StBusy : StDone;
      StBusy: begin
        if (md_done)      state_d = StDone;
        else if (!md_busy) state_d = StIdle;
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Single-cycle result, including the divide-by-zero shortcut.
  always_comb begin
    r_res = '0;
    r_hi  = '0;
    r_car = 1'b0;
    r_of  = 1'b0;
    r_dz  = 1'b0;
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    case (op_e'(op))
      OpAdd: begin
        {r_car, r_res} = sum;
        r_of = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OpSub: begin
        {r_car, r_res} = dif;
        r_of = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
      end
      OpNot:  r_res = ~a;
      OpAnd:  r_res = a & b;
      OpOr:   r_res = a | b;
      OpXor:  r_res = a ^ b;
      OpSlt:  r_res = W'($signed(a) < $signed(b));
      OpEq:   r_res = W'(a == b);
      OpDivu: begin
        r_res = '1;
        r_hi  = a;
        r_dz  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    res_d    = res_q;
    res_hi_d = res_hi_q;
    car_d    = car_q;
    of_d     = of_q;
    dz_d     = dz_q;
    if (accept && !iterative) begin
      res_d    = r_res;
      res_hi_d = r_hi;
      car_d    = r_car;
      of_d     = r_of;
      dz_d     = r_dz;
    end else if ((state_q == StBusy) && md_done) begin
      res_d    = md_lo;
      res_hi_d = md_hi;
      car_d    = 1'b0;
      of_d     = 1'b0;
      dz_d     = 1'b0;
    end
    zf_d = (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      res_hi_q <= '0;
      car_q    <= 1'b0;
      of_q     <= 1'b0;
      zf_q     <= 1'b1;
      dz_q     <= 1'b0;
    end else begin
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      car_q    <= car_d;
      of_q     <= of_d;
      zf_q     <= zf_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    res       = res_q;
    res_hi    = res_hi_q;
    car       = car_q;
    of        = of_q;
    zf        = zf_q;
    dz        = dz_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus random bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         car, of, zf, dz;
  logic [W-1:0] a, b, res, res_hi;
  logic [3:0]   op;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .W(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .res_hi   (res_hi),
    .car      (car),
    .of       (of),
    .zf       (zf),
    .dz       (dz)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sval(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  // Reference model from the opcode definitions, using integer arithmetic.
  function automatic void model(input int o, input int av, input int bv,
                                output int r, output int rh, output int c, output int ov,
                                output int z, output int d, output int lat);
    int mask, s, smin, smax;
    mask = (1 << W) - 1;
    smin = -(1 << (W - 1));
    smax = (1 << (W - 1)) - 1;
    r = 0; rh = 0; c = 0; ov = 0; d = 0; lat = 1;
    case (o)
      0: begin
        s = av + bv; r = s & mask; c = s >> W;
        ov = ((sval(av) + sval(bv)) > smax || (sval(av) + sval(bv)) < smin) ? 1 : 0;
      end
      1: begin
        s = av + ((~bv) & mask) + 1; r = s & mask; c = (s >> W) & 1;
        ov = ((sval(av) - sval(bv)) > smax || (sval(av) - sval(bv)) < smin) ? 1 : 0;
      end
      2: r = (~av) & mask;
      3: r = av & bv;
      4: r = av | bv;
      5: r = av ^ bv;
      6: r = (sval(av) < sval(bv)) ? 1 : 0;
      7: r = (av == bv) ? 1 : 0;
      8: begin
        s = av * bv; r = s & mask; rh = s >> W; lat = W + 1;
      end
      9: begin
        if (bv == 0) begin
          r = mask; rh = av; d = 1;
        end else begin
          r = av / bv; rh = av % bv; lat = W + 1;
        end
      end
      default: ;
    endcase
    z = (r == 0) ? 1 : 0;
  endfunction

  task automatic check_outs(input string tag, input int er, input int erh, input int ec,
                            input int eo, input int ez, input int ed);
    chk({tag, ".res"}, int'(res), er);
    chk({tag, ".res_hi"}, int'(res_hi), erh);
    chk({tag, ".car"}, int'(car), ec);
    chk({tag, ".of"}, int'(of), eo);
    chk({tag, ".zf"}, int'(zf), ez);
    chk({tag, ".dz"}, int'(dz), ed);
  endtask

  // Issue one op, measure latency, hold backpressure for `hold` cycles, then retire.
  task automatic run_op(input int o, input int av, input int bv, input int hold);
    int er, erh, ec, eo, ez, ed, lat, cyc;
    model(o, av, bv, er, erh, ec, eo, ez, ed, lat);
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    a = W'(av); b = W'(bv); op = 4'(o); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 4 * W + 8) begin
      chk("in_ready_busy", int'(in_ready), 0);
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("latency_op%0d", o), cyc, lat);
    check_outs($sformatf("op%0d_a%0d_b%0d", o, av, bv), er, erh, ec, eo, ez, ed);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); op = 4'($urandom);
      @(posedge clk); #1;
      chk("hold.out_valid", int'(out_valid), 1);
      chk("hold.in_ready", int'(in_ready), 0);
      check_outs("hold", er, erh, ec, eo, ez, ed);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("retire.out_valid", int'(out_valid), 0);
    chk("retire.in_ready", int'(in_ready), 1);
    check_outs("retire_keep", er, erh, ec, eo, ez, ed);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", int'(in_ready), 1);
    chk("reset.out_valid", int'(out_valid), 0);
    check_outs("reset", 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 7, 1, 0);
    run_op(1, 0, 1, 0);
    run_op(1, 5, 5, 0);
    run_op(6, 8, 7, 0);
    run_op(6, 7, 8, 0);
    run_op(7, 9, 9, 0);
    run_op(8, 15, 15, 3);
    run_op(9, 13, 4, 0);
    run_op(9, 13, 0, 3);
    run_op(12, 5, 3, 1);
    run_op(0, 8, 8, 0);

    // Reset during the second cycle of a multiply aborts it.
    @(negedge clk);
    a = 4'd15; b = 4'd15; op = 4'd8; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset.in_ready", int'(in_ready), 1);
    chk("midreset.out_valid", int'(out_valid), 0);
    check_outs("midreset", 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1;
    end
    chk("midreset.no_out_valid", seen_valid, 0);
    @(negedge clk);
    out_ready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 4-bit combinational ALU. Adds a registered result, a valid/ready interface on both sides, a zero flag, and multi-cycle unsigned multiply and divide. Sits between the lab's operand source (switches or CPU decode) and its result consumer (seven-segment driver or writeback). One operation is in flight at a time.

## Interface
- `W`, default 4: operand and result width, ≥2.
- `clk`, input, 1: single clock; every register updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands and opcode are valid.
- `in_ready`, output, 1: block can accept an operation.
- `a`, input, W: operand A.
- `b`, input, W: operand B.
- `op`, input, 4: opcode, `alu_pkg::op_e`.
- `out_valid`, output, 1: result is valid.
- `out_ready`, input, 1: consumer takes the result.
- `res`, output, W: result, or the low product word, or the quotient.
- `res_hi`, output, W: high product word or remainder; 0 for all other ops.
- `car`, output, 1: carry out (ADD), or no-borrow (SUB).
- `of`, output, 1: signed overflow (ADD/SUB only).
- `zf`, output, 1: `res == 0`.
- `dz`, output, 1: division by zero (DIVU only).

## Operation
- Opcodes:
  - 0 ADD: `{car,res} = a + b`.
  - 1 SUB: `{car,res} = a + ~b + 1`.
  - 2 NOT: `~a`.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLT: `res = 1` if `a < b` signed, else 0.
  - 7 EQ: `res = 1` if `a == b`, else 0.
  - 8 MULU: `{res_hi,res} = a*b` unsigned.
  - 9 DIVU: `res = a/b`, `res_hi = a%b` unsigned.
  - 10–15: illegal; `res = 0`, `res_hi = 0`, `car = of = dz = 0`, `zf = 1`.
- Overflow:
  - ADD: `of = (a[W-1]==b[W-1]) & (res[W-1]!=a[W-1])`.
  - SUB: `of = (a[W-1]!=b[W-1]) & (res[W-1]!=a[W-1])`.
- `car` and `of` are 0 for every op other than ADD and SUB.
- All arithmetic wraps modulo 2^W; there are no saturating modes.
- DIVU with `b == 0`: `res` = all ones, `res_hi = a`, `dz = 1`, `car = of = 0`.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready = 1`. Accept occurs when `in_valid & in_ready`.
    - Ops 0–7 and illegal ops: result computed and registered on the accept edge; go to DONE.
    - MULU/DIVU: latch operands, load the iteration counter with W; go to BUSY.
    - DIVU with `b == 0`: skip iteration; go directly to DONE with the divide-by-zero result.
  - BUSY: one shift-add (MULU) or restoring subtract-shift (DIVU) step per cycle, counter decrements. When the counter reaches 0, register the result and go to DONE.
  - DONE: `out_valid = 1`. When `out_ready` is high, return to IDLE.
- `in_ready` is 0 in BUSY and DONE; inputs are ignored there.
- No bypass: an accept and a retire never happen in the same cycle.
- `res`, `res_hi` and flags hold stable from `out_valid` rise until the handshake completes. Afterwards they keep their value until the next result is registered.

## Timing
- Reset values: state IDLE, `in_ready = 1`, `out_valid = 0`, `res = 0`, `res_hi = 0`, `car = of = dz = 0`, `zf = 1`, counter 0.
- Reset in any state, including mid-BUSY, aborts the operation at that edge. Nothing is emitted for the aborted op.
- Latency from the accept edge to `out_valid` high:
  - Ops 0–7, illegal ops, and DIVU by zero: 1 cycle.
  - MULU and DIVU: W+1 cycles (W iterations plus one register cycle).
- Throughput: one op per (latency + 1) cycles when `out_ready` is held at 1.
- `out_valid` is held indefinitely under backpressure and never drops without a handshake.

## Structure
- `alu_pkg`:
  - `op_e` (4-bit opcode enum).
  - `state_e` (IDLE/BUSY/DONE).
  - Opcode-count constant.
- Sub-module `alu_muldiv` (parameter W): iterative multiply/divide datapath.
  - Inputs: start, op select, operands.
  - Outputs: busy/done and the two result words.
  - Also owns the counter.
- The top level holds the FSM, the single-cycle ops and the flag logic.

## Test plan
- W=4, ADD a=7 b=1 → `res = 8`, `car = 0`, `of = 1`, `zf = 0`, `out_valid` 1 cycle after accept.
- W=4, SUB a=0 b=1 → `res = 15`, `car = 0`, `of = 0`. SUB a=5 b=5 → `res = 0`, `car = 1`, `zf = 1`.
- W=4, SLT a=8 b=7 → `res = 1`. SLT a=7 b=8 → `res = 0`. EQ a=9 b=9 → `res = 1`.
- W=4, MULU a=15 b=15 → `res = 1`, `res_hi = 14`, `out_valid` exactly 5 cycles after accept; `in_ready = 0` throughout.
- W=4:
  - DIVU a=13 b=4 → `res = 3`, `res_hi = 1`, `dz = 0`.
  - DIVU a=13 b=0 → `res = 15`, `res_hi = 13`, `dz = 1`, 1-cycle latency.
- Control and backpressure:
  - `out_ready` held low for 3 cycles in DONE → outputs stable, then retire and `in_ready = 1` next cycle.
  - `rst` asserted in cycle 2 of a MULU → IDLE with reset values, and no `out_valid` follows.
